// File: rtl/svs_monitor_ctrl.sv
// ---------------------------------------------------------------------------
// svs_monitor_ctrl
//
// Sequences a sweep over NB_MONITOR SVS ring monitors:
//   clear counters -> count for a window -> settle -> scan every monitor
//   for the slowest masked count -> nudge the voltage target code.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             single-cycle sweep request (accepted only in IDLE)
//   i_abort             cancel a sweep in progress; beats i_start in IDLE
//   i_window            measurement window in cycles (0 behaves as 1)
//   i_mon_mask          monitors taking part in the sweep
//   i_thr_low/high      speed thresholds compared against the minimum count
//   i_count             packed monitor counts, monitor k at [k*COUNT_W +: COUNT_W]
//   o_mon_clear         monitor counter clear (CLEAR state)
//   o_mon_en            per-monitor count enable (MEASURE state only)
//   o_busy              FSM not in IDLE
//   o_done              sweep complete (UPDATE state), results already valid
//   o_err_no_mon        pulse when a start arrives with an empty mask
//   o_min_count         slowest masked count of the last completed sweep
//   o_min_idx           index of that monitor
//   o_target            saturating voltage target code
//   o_state             current FSM state, for debug observation
//
// Handshake: i_start is a request pulse, not a valid/ready pair. It is
// sampled on the rising edge only while o_busy=0 and i_abort=0; results are
// qualified by the one-cycle o_done pulse and then hold until the next one.
// ---------------------------------------------------------------------------
module svs_monitor_ctrl #(
    parameter int NB_MONITOR = 30,
    parameter int COUNT_W    = 16,
    parameter int TARGET_W   = 3,
    parameter int WINDOW_W   = 16,
    parameter int SETTLE_CYC = 2,
    parameter int TARGET_RST = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic [WINDOW_W-1:0]             i_window,
    input  logic [NB_MONITOR-1:0]           i_mon_mask,
    input  logic [COUNT_W-1:0]              i_thr_low,
    input  logic [COUNT_W-1:0]              i_thr_high,
    input  logic [NB_MONITOR*COUNT_W-1:0]   i_count,
    output logic                            o_mon_clear,
    output logic [NB_MONITOR-1:0]           o_mon_en,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err_no_mon,
    output logic [COUNT_W-1:0]              o_min_count,
    output logic [$clog2(NB_MONITOR)-1:0]   o_min_idx,
    output logic [TARGET_W-1:0]             o_target,
    output logic [2:0]                      o_state
);

    localparam int IDX_W = $clog2(NB_MONITOR);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NB_MONITOR - 1);
    localparam logic [TARGET_W-1:0] TARGET_MAX  = {TARGET_W{1'b1}};
    localparam logic [WINDOW_W-1:0] SETTLE_LOAD =
        (SETTLE_CYC > 0) ? WINDOW_W'(SETTLE_CYC - 1) : '0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        MEASURE = 3'd2,
        SETTLE  = 3'd3,
        SCAN    = 3'd4,
        UPDATE  = 3'd5
    } state_t;

    state_t state, next;

    // Latched sweep configuration
    logic [WINDOW_W-1:0]   win_q;
    logic [NB_MONITOR-1:0] mask_q;
    logic [COUNT_W-1:0]    lo_q, hi_q;

    // Down-counter shared by MEASURE and SETTLE, scan pointer and running min
    logic [WINDOW_W-1:0]   cnt;
    logic [IDX_W-1:0]      idx;
    logic [COUNT_W-1:0]    best_cnt;
    logic [IDX_W-1:0]      best_idx;
    logic                  found;

    logic [COUNT_W-1:0]    min_count_r;
    logic [IDX_W-1:0]      min_idx_r;
    logic [TARGET_W-1:0]   target_r;
    logic                  err_r;

    logic                  start_ok;
    logic [COUNT_W-1:0]    cur;
    logic                  take;
    logic [COUNT_W-1:0]    fin_cnt;
    logic [IDX_W-1:0]      fin_idx;
    logic [TARGET_W-1:0]   new_target;

    // Abort wins over start when both arrive together in IDLE.
    assign start_ok = i_start && !i_abort;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next = state;
        if (state != IDLE && i_abort) begin
            next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok && (i_mon_mask != '0)) next = CLEAR;
                CLEAR:   next = MEASURE;
                MEASURE: if (cnt == '0) next = (SETTLE_CYC > 0) ? SETTLE : SCAN;
                SETTLE:  if (cnt == '0) next = SCAN;
                SCAN:    if (idx == LAST_IDX) next = UPDATE;
                UPDATE:  next = IDLE;
                default: next = IDLE;
            endcase
        end
    end

    // ---------------- scan / result datapath ----------------
    // The monitor examined this SCAN cycle is folded in combinationally so the
    // final cycle's index is part of the result registered on entry to UPDATE.
    // Strict '<' keeps the earlier (lower) index on ties.
    always_comb begin
        cur     = i_count[int'(idx)*COUNT_W +: COUNT_W];
        take    = mask_q[idx] && (!found || (cur < best_cnt));
        fin_cnt = take ? cur : best_cnt;
        fin_idx = take ? idx : best_idx;
        if (fin_cnt < lo_q) begin
            new_target = (target_r == TARGET_MAX) ? target_r : target_r + 1'b1;
        end else if (fin_cnt > hi_q) begin
            new_target = (target_r == '0) ? target_r : target_r - 1'b1;
        end else begin
            new_target = target_r;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            win_q       <= '0;
            mask_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            cnt         <= '0;
            idx         <= '0;
            best_cnt    <= '0;
            best_idx    <= '0;
            found       <= 1'b0;
            min_count_r <= '1;
            min_idx_r   <= '0;
            target_r    <= TARGET_W'(TARGET_RST);
            err_r       <= 1'b0;
        end else begin
            err_r <= (state == IDLE) && start_ok && (i_mon_mask == '0);
            case (state)
                IDLE: begin
                    if (start_ok && (i_mon_mask != '0)) begin
                        win_q  <= (i_window == '0) ? WINDOW_W'(1) : i_window;
                        mask_q <= i_mon_mask;
                        lo_q   <= i_thr_low;
                        hi_q   <= i_thr_high;
                    end
                end
                CLEAR: begin
                    cnt   <= win_q - 1'b1;
                    idx   <= '0;
                    found <= 1'b0;
                end
                MEASURE: begin
                    cnt <= (cnt == '0) ? SETTLE_LOAD : cnt - 1'b1;
                end
                SETTLE: begin
                    cnt <= cnt - 1'b1;
                end
                SCAN: begin
                    idx <= idx + 1'b1;
                    if (take) begin
                        best_cnt <= cur;
                        best_idx <= idx;
                        found    <= 1'b1;
                    end
                    // An abort on the last SCAN cycle leaves results untouched.
                    if (next == UPDATE) begin
                        min_count_r <= fin_cnt;
                        min_idx_r   <= fin_idx;
                        target_r    <= new_target;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        o_mon_clear = (state == CLEAR);
        o_mon_en    = (state == MEASURE) ? mask_q : '0;
        o_busy      = (state != IDLE);
        o_done      = (state == UPDATE);
        o_state     = state;
    end

    assign o_err_no_mon = err_r;
    assign o_min_count  = min_count_r;
    assign o_min_idx    = min_idx_r;
    assign o_target     = target_r;

endmodule

// File: tb/tb_svs_monitor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_svs_monitor_ctrl
//
// Directed bench. Drivers push the expected o_done / o_err_no_mon event
// (cycle, min count, min index, target) into exp_q when a start is issued; a
// separate negedge monitor pops and compares whenever the DUT raises either
// pulse. A pulse with nothing queued is reported as unexpected.
// ---------------------------------------------------------------------------
module tb_svs_monitor_ctrl;

    localparam int NB = 30;
    localparam int CW = 16;
    localparam logic [NB-1:0] ALL = {NB{1'b1}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              i_start, i_abort;
    logic [15:0]       i_window;
    logic [NB-1:0]     i_mon_mask;
    logic [CW-1:0]     i_thr_low, i_thr_high;
    logic [NB*CW-1:0]  i_count;
    logic              o_mon_clear, o_busy, o_done, o_err_no_mon;
    logic [NB-1:0]     o_mon_en;
    logic [CW-1:0]     o_min_count;
    logic [4:0]        o_min_idx;
    logic [2:0]        o_target;
    logic [2:0]        o_state;

    svs_monitor_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_window     (i_window),
        .i_mon_mask   (i_mon_mask),
        .i_thr_low    (i_thr_low),
        .i_thr_high   (i_thr_high),
        .i_count      (i_count),
        .o_mon_clear  (o_mon_clear),
        .o_mon_en     (o_mon_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err_no_mon (o_err_no_mon),
        .o_min_count  (o_min_count),
        .o_min_idx    (o_min_idx),
        .o_target     (o_target),
        .o_state      (o_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        kind;   // 0 = done, 1 = empty-mask error
        logic [31:0] cyc;
        logic [15:0] cnt;
        logic [4:0]  idx;
        logic [2:0]  tgt;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (o_done || o_err_no_mon)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got done=%0b err=%0b expected none (cycle %0d)",
                         o_done, o_err_no_mon, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_kind",  32'(o_err_no_mon), 32'(e.kind));
                chk("event_done",  32'(o_done),       32'(!e.kind));
                chk("event_cycle", 32'(cyc),          e.cyc);
                chk("min_count",   32'(o_min_count),  32'(e.cnt));
                chk("min_idx",     32'(o_min_idx),    32'(e.idx));
                chk("target",      32'(o_target),     32'(e.tgt));
                if (e.kind) chk("err_busy", 32'(o_busy), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Perturb configuration inputs after a start: latched values must be used.
    task automatic scramble();
        i_window   = 16'($urandom_range(0, 200));
        i_mon_mask = NB'($urandom);
        i_thr_low  = 16'($urandom);
        i_thr_high = 16'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle_timeout", 32'(ok), 32'd1);
    endtask

    function automatic int lat_of(input logic [15:0] w);
        return ((w == 0) ? 1 : int'(w)) + 2 + NB + 2;
    endfunction

    task automatic sweep(input logic [15:0] w, input logic [NB-1:0] m,
                         input logic [15:0] lo, input logic [15:0] hi,
                         input logic [15:0] ecnt, input logic [4:0] eidx,
                         input logic [2:0] etgt);
        @(negedge clk);
        i_window = w; i_mon_mask = m; i_thr_low = lo; i_thr_high = hi;
        i_start = 1'b1;
        exp_q.push_back(exp_t'{1'b0, 32'(cyc + lat_of(w)), ecnt, eidx, etgt});
        @(negedge clk);
        i_start = 1'b0;
        scramble();
        wait_idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   32'(o_busy),      32'd0);
        chk({tag, "_mon_en"}, 32'(o_mon_en),    32'd0);
        chk({tag, "_clear"},  32'(o_mon_clear), 32'd0);
        chk({tag, "_done"},   32'(o_done),      32'd0);
        chk({tag, "_err"},    32'(o_err_no_mon),32'd0);
        chk({tag, "_min"},    32'(o_min_count), 32'hffff);
        chk({tag, "_idx"},    32'(o_min_idx),   32'd0);
        chk({tag, "_target"}, 32'(o_target),    32'd4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [2:0] sat_up [5];
        logic [2:0] sat_dn [8];
        sat_up = '{3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
        sat_dn = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

        i_start = 1'b0; i_abort = 1'b0;
        i_window = '0; i_mon_mask = '0; i_thr_low = '0; i_thr_high = '0;
        for (int k = 0; k < NB; k++) i_count[k*CW +: CW] = 16'(1000 + k);
        i_count[17*CW +: CW] = 16'd500;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Basic sweep: monitor 17 is slowest, below thr_low -> target up.
        sweep(16'd100, ALL, 16'd600, 16'd1200, 16'd500, 5'd17, 3'd5);

        // Tie between 3 and 9: masked-off 3 loses, unmasked 3 wins (lower index).
        i_count[3*CW +: CW] = 16'd200;
        i_count[9*CW +: CW] = 16'd200;
        sweep(16'd5, ALL & ~(NB'(1) << 3), 16'd600, 16'd1200, 16'd200, 5'd9, 3'd6);
        sweep(16'd5, ALL,                  16'd600, 16'd1200, 16'd200, 5'd3, 3'd7);

        // Reset while idle returns target to its reset code.
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("idle_reset_target", 32'(o_target), 32'd4);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation upward, then downward, then threshold boundaries.
        for (int s = 0; s < 5; s++)
            sweep(16'd0, ALL, 16'd600, 16'd1200, 16'd200, 5'd3, sat_up[s]);
        for (int s = 0; s < 8; s++)
            sweep(16'd1, ALL, 16'd0, 16'd100, 16'd200, 5'd3, sat_dn[s]);
        sweep(16'd1, ALL, 16'd300, 16'd100, 16'd200, 5'd3, 3'd1);  // overlap: low wins
        sweep(16'd1, ALL, 16'd200, 16'd200, 16'd200, 5'd3, 3'd1);  // equal: hold

        // Abort in MEASURE cycle 10, then restart immediately.
        @(negedge clk);
        n = cyc;
        i_window = 16'd50; i_mon_mask = ALL; i_thr_low = 16'd600; i_thr_high = 16'd1200;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (cyc < n + 11) @(negedge clk);
        chk("measure_mon_en", 32'(o_mon_en), 32'(ALL));
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_mon_en", 32'(o_mon_en), 32'd0);
        chk("abort_busy",   32'(o_busy),   32'd0);
        chk("abort_target", 32'(o_target), 32'd1);
        i_start = 1'b1;
        exp_q.push_back(exp_t'{1'b0, 32'(cyc + lat_of(16'd50)), 16'd200, 5'd3, 3'd2});
        @(negedge clk);
        i_start = 1'b0;
        wait_idle();

        // Empty mask: one-cycle error, no sweep, results untouched.
        @(negedge clk);
        i_mon_mask = '0; i_window = 16'd10;
        i_start = 1'b1;
        exp_q.push_back(exp_t'{1'b1, 32'(cyc + 1), 16'd200, 5'd3, 3'd2});
        @(negedge clk);
        i_start = 1'b0;
        chk("empty_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("empty_err_single", 32'(o_err_no_mon), 32'd0);
        chk("empty_busy2",      32'(o_busy),       32'd0);

        // Start pulsed during SCAN is ignored; upper monitors only, in-range.
        @(negedge clk);
        n = cyc;
        i_window = 16'd1; i_mon_mask = NB'(30'h3FF0_0000);
        i_thr_low = 16'd600; i_thr_high = 16'd1200;
        i_start = 1'b1;
        exp_q.push_back(exp_t'{1'b0, 32'(n + lat_of(16'd1)), 16'd1020, 5'd20, 3'd2});
        @(negedge clk);
        i_start = 1'b0;
        scramble();
        while (cyc < n + 15) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // Reset during SCAN: no done afterwards, outputs at reset values.
        @(negedge clk);
        n = cyc;
        i_window = 16'd1; i_mon_mask = ALL;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (cyc < n + 20) @(negedge clk);
        chk("pre_reset_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1 chk_reset_vals("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_reset_target", 32'(o_target), 32'd4);

        // Zero window behaves as one; then a sweep selecting only the last index.
        sweep(16'd0, ALL, 16'd600, 16'd1200, 16'd200, 5'd3, 3'd5);
        sweep(16'd2, NB'(1) << 29, 16'd600, 16'd1200, 16'd1029, 5'd29, 3'd5);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
